// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and rotate/encode helpers for the
// 8259A-compatible priority arbiter and its priority encoder.
package pic_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Rotate an 8-bit vector right by 0..7 positions.
  function automatic logic [7:0] rotate_right8(input logic [7:0] value,
                                               input logic [LEVEL_W-1:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[7:0];
  endfunction

  // Rotate an 8-bit vector left by 0..7 positions.
  function automatic logic [7:0] rotate_left8(input logic [7:0] value,
                                              input logic [LEVEL_W-1:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} << amount;
    return doubled[15:8];
  endfunction

  // Encode a one-hot (or zero) vector into a bit index; zero encodes as 0.
  function automatic logic [LEVEL_W-1:0] onehot_to_index(input logic [7:0] onehot);
    logic [LEVEL_W-1:0] index;
    index = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) index = index | LEVEL_W'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/pic_priority_encoder.sv
// pic_priority_encoder: finds the highest-priority set bit of an 8-bit vector
// under rotating priority, where lowest_pri+1 is highest and lowest_pri is
// lowest (mod 8). Returns found, the level index and its one-hot form.
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0]         vec,
  input  logic [LEVEL_W-1:0] lowest_pri,
  output logic               found,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         onehot
);

  logic [LEVEL_W-1:0] top_level;
  logic [7:0]         rotated;
  logic [7:0]         rot_onehot;

  // Rotate so the highest-priority level lands on bit 0, isolate the lowest
  // set bit there, then rotate back into absolute level positions.
  assign top_level  = lowest_pri + LEVEL_W'(1);
  assign rotated    = rotate_right8(vec, top_level);
  assign rot_onehot = rotated & (~rotated + 8'd1);
  assign onehot     = rotate_left8(rot_onehot, top_level);
  assign found      = |vec;
  assign level      = onehot_to_index(onehot);

endmodule

// File: rtl/pic_priority_arbiter.sv
// pic_priority_arbiter: priority resolver and in-service manager of an
// 8259A-compatible PIC. Arbitrates IRR against IMR/ISR for the INT line,
// sequences the two-pulse INTA and poll, owns ISR and the rotating priority
// pointer, and executes OCW2 EOI / rotate / set-priority commands.
// Optional feature macro: PIC_SPECIAL_FULLY_NESTED_EN adds the
// special_fully_nested input (same-level re-interrupt for cascaded slaves).
module pic_priority_arbiter
  import pic_pkg::*;
#(
  parameter int                  NUM_IR           = 8,
  parameter logic [LEVEL_W-1:0]  LOWEST_PRI_RESET = 3'd7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IR-1:0]  irr,
  input  logic [NUM_IR-1:0]  imr,
  input  logic               special_mask_mode,
  input  logic               auto_eoi,
  input  logic               auto_rotate,
  input  logic               ack1,
  input  logic               ack2,
  input  logic               poll,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic               set_priority,
  input  logic               rotate,
  input  logic [LEVEL_W-1:0] cmd_level,
`ifdef PIC_SPECIAL_FULLY_NESTED_EN
  input  logic               special_fully_nested,
`endif
  output logic               int_req,
  output logic [LEVEL_W-1:0] ack_level,
  output logic               ack_valid,
  output logic [NUM_IR-1:0]  clear_irr,
  output logic [NUM_IR-1:0]  isr,
  output logic [NUM_IR-1:0]  highest_in_service
);

  state_t             state;
  state_t             state_next;
  logic [LEVEL_W-1:0] lowest_pri;
  logic [LEVEL_W-1:0] lowest_pri_next;
  logic [LEVEL_W-1:0] ack_level_next;
  logic               ack_valid_next;
  logic [NUM_IR-1:0]  isr_next;
  logic [NUM_IR-1:0]  set_mask;
  logic [NUM_IR-1:0]  clr_mask;

  logic [NUM_IR-1:0]  candidates;
  logic [NUM_IR-1:0]  allowed_rot;
  logic [NUM_IR-1:0]  allowed;
  logic [NUM_IR-1:0]  eligible;
  logic [LEVEL_W-1:0] isr_rank;
  logic               same_level_ok;

  logic               isr_found;
  logic [LEVEL_W-1:0] isr_level;
  logic               win_found;
  logic [LEVEL_W-1:0] win_level;
  logic [NUM_IR-1:0]  win_onehot;

  logic               take;
  logic               aeoi_done;

`ifdef PIC_SPECIAL_FULLY_NESTED_EN
  assign same_level_ok = special_fully_nested;
`else
  assign same_level_ok = 1'b0;
`endif

  // Highest in-service level; its one-hot form is the highest_in_service output.
  pic_priority_encoder u_isr_enc (
    .vec        (isr),
    .lowest_pri (lowest_pri),
    .found      (isr_found),
    .level      (isr_level),
    .onehot     (highest_in_service)
  );

  // Levels that may interrupt: in normal mode only those ranked above the
  // highest in-service level (rank 0 = highest priority); in special mask
  // mode any level not itself in service.
  assign candidates  = irr & ~imr;
  assign isr_rank    = isr_level - (lowest_pri + LEVEL_W'(1));
  assign allowed_rot = !isr_found    ? 8'hFF :
                       same_level_ok ? ((8'd2 << isr_rank) - 8'd1) :
                                       ((8'd1 << isr_rank) - 8'd1);
  assign allowed     = rotate_left8(allowed_rot, lowest_pri + LEVEL_W'(1));
  assign eligible    = special_mask_mode ? (candidates & ~isr)
                                         : (candidates & allowed);

  pic_priority_encoder u_cand_enc (
    .vec        (eligible),
    .lowest_pri (lowest_pri),
    .found      (win_found),
    .level      (win_level),
    .onehot     (win_onehot)
  );

  // Next-state logic of the acknowledge sequencer.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    aeoi_done  = 1'b0;
    case (state)
      IDLE, REQ: begin
        if (ack1 || poll) begin
          take       = 1'b1;
          state_next = ack1 ? ACK : IDLE;
        end else begin
          state_next = win_found ? REQ : IDLE;
        end
      end
      ACK: begin
        if (ack2) begin
          state_next = IDLE;
          aeoi_done  = auto_eoi && ack_valid;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of ISR, the priority pointer and the acknowledge latch.
  always_comb begin
    set_mask = (take && win_found) ? win_onehot : '0;

    clr_mask = '0;
    if (eoi_nonspecific) clr_mask = clr_mask | highest_in_service;
    if (eoi_specific)    clr_mask = clr_mask | (8'd1 << cmd_level);
    if (aeoi_done)       clr_mask = clr_mask | (8'd1 << ack_level);

    // A set in the same cycle as a clear of the same bit wins.
    isr_next = (isr & ~clr_mask) | set_mask;

    lowest_pri_next = lowest_pri;
    if (set_priority) begin
      lowest_pri_next = cmd_level;
    end else if (eoi_specific && rotate) begin
      lowest_pri_next = cmd_level;
    end else if (eoi_nonspecific && rotate && isr_found) begin
      lowest_pri_next = isr_level;
    end else if (aeoi_done && auto_rotate) begin
      lowest_pri_next = ack_level;
    end

    ack_level_next = ack_level;
    ack_valid_next = ack_valid;
    if (take) begin
      ack_level_next = win_found ? win_level : SPURIOUS_LEVEL;
      ack_valid_next = win_found;
    end
  end

  // Sequencer state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lowest_pri <= LOWEST_PRI_RESET;
      isr        <= '0;
      clear_irr  <= '0;
      int_req    <= 1'b0;
      ack_level  <= '0;
      ack_valid  <= 1'b0;
    end else begin
      lowest_pri <= lowest_pri_next;
      isr        <= isr_next;
      clear_irr  <= set_mask;
      int_req    <= (state_next == REQ);
      ack_level  <= ack_level_next;
      ack_valid  <= ack_valid_next;
    end
  end

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// tb_pic_priority_arbiter: directed cycle table for the documented scenarios,
// a few hand-written corner sequences, then randomized stimulus checked
// against a level-order reference model of the PIC rules.
module tb_pic_priority_arbiter;

  localparam int OP_NONE      = 0;
  localparam int OP_ACK1      = 1;
  localparam int OP_ACK2      = 2;
  localparam int OP_POLL      = 3;
  localparam int OP_EOIN      = 4;
  localparam int OP_EOIS      = 5;
  localparam int OP_SETP      = 6;
  localparam int OP_ACK1_EOIS = 7;
  localparam int OP_SETP_EOIN = 8;

  localparam logic [2:0] M_NONE = 3'b000;  // {smm, aeoi, arot}
  localparam logic [2:0] M_SMM  = 3'b100;
  localparam logic [2:0] M_AROT = 3'b011;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [2:0] mode;
    int         op;
    logic       rot;
    logic [2:0] lvl;
    logic       e_int;
    logic [2:0] e_lvl;
    logic       e_vld;
    logic [7:0] e_clr;
    logic [7:0] e_isr;
    logic [7:0] e_his;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       special_mask_mode, auto_eoi, auto_rotate;
  logic       ack1, ack2, poll, eoi_nonspecific, eoi_specific, set_priority, rotate;
  logic [2:0] cmd_level;
  logic       special_fully_nested;
  logic       int_req;
  logic [2:0] ack_level;
  logic       ack_valid;
  logic [7:0] clear_irr, isr, highest_in_service;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_isr, m_clr;
  logic [2:0] m_ptr, m_lvl;
  logic       m_vld, m_int, m_in_ack;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pic_priority_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .irr                (irr),
    .imr                (imr),
    .special_mask_mode  (special_mask_mode),
    .auto_eoi           (auto_eoi),
    .auto_rotate        (auto_rotate),
    .ack1               (ack1),
    .ack2               (ack2),
    .poll               (poll),
    .eoi_nonspecific    (eoi_nonspecific),
    .eoi_specific       (eoi_specific),
    .set_priority       (set_priority),
    .rotate             (rotate),
    .cmd_level          (cmd_level),
`ifdef PIC_SPECIAL_FULLY_NESTED_EN
    .special_fully_nested (special_fully_nested),
`endif
    .int_req            (int_req),
    .ack_level          (ack_level),
    .ack_valid          (ack_valid),
    .clear_irr          (clear_irr),
    .isr                (isr),
    .highest_in_service (highest_in_service)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] irr_v, input logic [7:0] imr_v,
                              input logic [2:0] mode, input int op, input logic rot,
                              input logic [2:0] lvl, input logic e_int,
                              input logic [2:0] e_lvl, input logic e_vld,
                              input logic [7:0] e_clr, input logic [7:0] e_isr,
                              input logic [7:0] e_his);
    vec_t v;
    v.irr = irr_v;  v.imr = imr_v;  v.mode = mode;  v.op = op;
    v.rot = rot;    v.lvl = lvl;    v.e_int = e_int; v.e_lvl = e_lvl;
    v.e_vld = e_vld; v.e_clr = e_clr; v.e_isr = e_isr; v.e_his = e_his;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    irr = v.irr;
    imr = v.imr;
    {special_mask_mode, auto_eoi, auto_rotate} = v.mode;
    ack1            = (v.op == OP_ACK1) || (v.op == OP_ACK1_EOIS);
    ack2            = (v.op == OP_ACK2);
    poll            = (v.op == OP_POLL);
    eoi_nonspecific = (v.op == OP_EOIN) || (v.op == OP_SETP_EOIN);
    eoi_specific    = (v.op == OP_EOIS) || (v.op == OP_ACK1_EOIS);
    set_priority    = (v.op == OP_SETP) || (v.op == OP_SETP_EOIN);
    rotate          = v.rot;
    cmd_level       = v.lvl;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    check({tag, " int_req"},   32'(int_req),            32'(v.e_int));
    check({tag, " ack_level"}, 32'(ack_level),          32'(v.e_lvl));
    check({tag, " ack_valid"}, 32'(ack_valid),          32'(v.e_vld));
    check({tag, " clear_irr"}, 32'(clear_irr),          32'(v.e_clr));
    check({tag, " isr"},       32'(isr),                32'(v.e_isr));
    check({tag, " his"},       32'(highest_in_service), 32'(v.e_his));
  endtask

  // Rank k of a level = position in the order ptr+1, ptr+2, ..., ptr (mod 8).
  function automatic int level_at(input logic [2:0] ptr, input int k);
    return (int'(ptr) + 1 + k) % 8;
  endfunction

  function automatic logic [7:0] model_his(input logic [7:0] vec, input logic [2:0] ptr);
    logic [7:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (vec[level_at(ptr, k)]) r = 8'd1 << level_at(ptr, k);
    end
    return r;
  endfunction

  // One clock of the PIC rules applied to the current inputs.
  task automatic model_step();
    int   top_k, top_lvl, win_lvl, l;
    logic win, take, aeoi, ok;
    logic [7:0] new_isr;
    top_k = 8; top_lvl = 0; win = 1'b0; win_lvl = 0;
    for (int k = 0; k < 8; k++) begin
      l = level_at(m_ptr, k);
      if (top_k == 8 && m_isr[l]) begin top_k = k; top_lvl = l; end
    end
    for (int k = 0; k < 8; k++) begin
      l  = level_at(m_ptr, k);
      ok = special_mask_mode ? !m_isr[l]
                             : (k < top_k) || (special_fully_nested && k == top_k);
      if (!win && irr[l] && !imr[l] && ok) begin win = 1'b1; win_lvl = l; end
    end
    take = !m_in_ack && (ack1 || poll);
    aeoi = m_in_ack && ack2 && auto_eoi && m_vld;
    new_isr = m_isr;
    if (eoi_nonspecific && top_k < 8) new_isr[top_lvl] = 1'b0;
    if (eoi_specific) new_isr[cmd_level] = 1'b0;
    if (aeoi) new_isr[m_lvl] = 1'b0;
    if (take && win) new_isr[win_lvl] = 1'b1;
    if (set_priority) m_ptr = cmd_level;
    else if (eoi_specific && rotate) m_ptr = cmd_level;
    else if (eoi_nonspecific && rotate && top_k < 8) m_ptr = 3'(top_lvl);
    else if (aeoi && auto_rotate) m_ptr = m_lvl;
    m_isr = new_isr;
    m_clr = (take && win) ? (8'd1 << win_lvl) : 8'd0;
    if (take) begin
      m_lvl = win ? 3'(win_lvl) : 3'd7;
      m_vld = win;
    end
    m_int    = !m_in_ack && !take && win;
    m_in_ack = m_in_ack ? !ack2 : ack1;
  endtask

  task automatic clear_inputs();
    irr = '0; imr = '0;
    special_mask_mode = 0; auto_eoi = 0; auto_rotate = 0;
    ack1 = 0; ack2 = 0; poll = 0;
    eoi_nonspecific = 0; eoi_specific = 0; set_priority = 0; rotate = 0;
    cmd_level = '0;
  endtask

  initial begin
    special_fully_nested = 1'b0;
    clear_inputs();
    reset = 1'b1;
    #12;
    check("reset int_req",   32'(int_req),            0);
    check("reset ack_level", 32'(ack_level),          0);
    check("reset ack_valid", 32'(ack_valid),          0);
    check("reset clear_irr", 32'(clear_irr),          0);
    check("reset isr",       32'(isr),                0);
    check("reset his",       32'(highest_in_service), 0);

    //               irr    imr    mode    op            rot lvl  int lvl vld clr    isr    his
    vecs.push_back(mk(8'h0A, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  0,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h0A, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  1,  1, 8'h02, 8'h02, 8'h02));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h09, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_EOIN,      0, 0,   0,  1,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  1,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  3,  1, 8'h08, 8'h08, 8'h08));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  3,  1, 8'h00, 8'h08, 8'h08));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_EOIN,      0, 0,   0,  3,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h01, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h01, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h01, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h10, 8'h00, M_AROT, OP_NONE,      0, 0,   1,  7,  0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h10, 8'h00, M_AROT, OP_ACK1,      0, 0,   0,  4,  1, 8'h10, 8'h10, 8'h10));
    vecs.push_back(mk(8'h00, 8'h00, M_AROT, OP_ACK2,      0, 0,   0,  4,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h21, 8'h00, M_AROT, OP_NONE,      0, 0,   1,  4,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h21, 8'h00, M_AROT, OP_ACK1,      0, 0,   0,  5,  1, 8'h20, 8'h20, 8'h20));
    vecs.push_back(mk(8'h01, 8'h00, M_AROT, OP_ACK2,      0, 0,   0,  5,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_SETP,      0, 7,   0,  5,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h02, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  5,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h02, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  1,  1, 8'h02, 8'h02, 8'h02));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h80, 8'h02, M_NONE, OP_NONE,      0, 0,   0,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h80, 8'h02, M_SMM,  OP_NONE,      0, 0,   1,  1,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h80, 8'h02, M_SMM,  OP_ACK1,      0, 0,   0,  7,  1, 8'h80, 8'h82, 8'h02));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  7,  1, 8'h00, 8'h82, 8'h02));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_EOIS,      0, 7,   0,  7,  1, 8'h00, 8'h02, 8'h02));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_EOIN,      1, 0,   0,  7,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h05, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  7,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h05, 8'h00, M_NONE, OP_POLL,      0, 0,   0,  2,  1, 8'h04, 8'h04, 8'h04));
    vecs.push_back(mk(8'h01, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  2,  1, 8'h00, 8'h04, 8'h04));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_EOIS,      0, 2,   0,  2,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_SETP,      0, 7,   0,  2,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  2,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_ACK1_EOIS, 0, 3,   0,  3,  1, 8'h08, 8'h08, 8'h08));
    vecs.push_back(mk(8'h08, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  3,  1, 8'h00, 8'h08, 8'h08));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_ACK2,      0, 0,   0,  3,  1, 8'h00, 8'h08, 8'h08));
    vecs.push_back(mk(8'h00, 8'h00, M_NONE, OP_SETP_EOIN, 1, 0,   0,  3,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h84, 8'h00, M_NONE, OP_NONE,      0, 0,   1,  3,  1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h84, 8'h00, M_NONE, OP_ACK1,      0, 0,   0,  2,  1, 8'h04, 8'h04, 8'h04));
    vecs.push_back(mk(8'h80, 8'h00, M_NONE, OP_NONE,      0, 0,   0,  2,  1, 8'h00, 8'h04, 8'h04));

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-ACK clears outputs without waiting for a clock edge.
    #2 reset = 1'b1;
    #1;
    check("midreset int_req",   32'(int_req),            0);
    check("midreset ack_level", 32'(ack_level),          0);
    check("midreset ack_valid", 32'(ack_valid),          0);
    check("midreset clear_irr", 32'(clear_irr),          0);
    check("midreset isr",       32'(isr),                0);
    check("midreset his",       32'(highest_in_service), 0);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Pointer is back at 7, so IR0 outranks IR1.
    apply(mk(8'h03, 8'h00, M_NONE, OP_NONE, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00), "post0");
    apply(mk(8'h03, 8'h00, M_NONE, OP_ACK1, 0, 0, 0, 0, 1, 8'h01, 8'h01, 8'h01), "post1");
    apply(mk(8'h02, 8'h00, M_NONE, OP_ACK2, 0, 0, 0, 0, 1, 8'h00, 8'h01, 8'h01), "post2");

    // Randomized run against the reference model.
    reset = 1'b1;
    clear_inputs();
    m_isr = '0; m_clr = '0; m_ptr = 3'd7; m_lvl = '0;
    m_vld = 0; m_int = 0; m_in_ack = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        special_mask_mode = ($urandom_range(0, 3) == 0);
        auto_eoi          = ($urandom_range(0, 1) == 0);
        auto_rotate       = ($urandom_range(0, 1) == 0);
`ifdef PIC_SPECIAL_FULLY_NESTED_EN
        special_fully_nested = ($urandom_range(0, 1) == 0);
`endif
      end
      irr             = 8'($urandom & $urandom);
      imr             = ((n / 50) % 2 == 1) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      ack1            = ($urandom_range(0, 4) == 0);
      ack2            = ($urandom_range(0, 3) == 0);
      poll            = ($urandom_range(0, 15) == 0);
      eoi_nonspecific = ($urandom_range(0, 7) == 0);
      eoi_specific    = ($urandom_range(0, 11) == 0);
      set_priority    = ($urandom_range(0, 19) == 0);
      rotate          = ($urandom_range(0, 1) == 0);
      cmd_level       = 3'($urandom_range(0, 7));
      model_step();
      @(posedge clk);
      #1;
      check("rnd int_req",   32'(int_req),            32'(m_int));
      check("rnd ack_level", 32'(ack_level),          32'(m_lvl));
      check("rnd ack_valid", 32'(ack_valid),          32'(m_vld));
      check("rnd clear_irr", 32'(clear_irr),          32'(m_clr));
      check("rnd isr",       32'(isr),                32'(m_isr));
      check("rnd his",       32'(highest_in_service), 32'(model_his(m_isr, m_ptr)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_priority_arbiter.md
Name: pic_priority_arbiter

Overview:
- Priority resolver and in-service manager for the 8259A-compatible PIC.
- Arbitrates the eight latched IR requests (IRR) for the single CPU INT line and owns the in-service register (ISR) and the rotating priority pointer.
- Executes EOI and rotate commands decoded from OCW2, and sequences the two-pulse INTA acknowledge and the OCW3 poll.
- Sits between the interrupt-detect logic (IRR/IMR source) and the control logic (INTA/poll/command strobes, vector generation).

Parameters:
- NUM_IR, 8, number of interrupt levels; level index width is 3.
- LOWEST_PRI_RESET, 3'd7, priority pointer reset value, giving IR0 highest priority.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irr  in  8  pending requests from detect logic
- imr  in  8  interrupt mask (1 = masked)
- special_mask_mode  in  1  OCW3 SMM active
- auto_eoi  in  1  ICW4 AEOI configured
- auto_rotate  in  1  rotate on AEOI enabled
- ack1  in  1  one-cycle pulse, first INTA falling edge
- ack2  in  1  one-cycle pulse, end of second INTA
- poll  in  1  one-cycle pulse, poll read completed
- eoi_nonspecific  in  1  one-cycle OCW2 non-specific EOI
- eoi_specific  in  1  one-cycle OCW2 specific EOI
- set_priority  in  1  one-cycle OCW2 set-priority command
- rotate  in  1  qualifier for the EOI commands
- cmd_level  in  3  level for specific EOI or set-priority
- int_req  out  1  INT to CPU
- ack_level  out  3  level latched at ack1/poll
- ack_valid  out  1  latched level is a real request (0 = spurious)
- clear_irr  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- isr  out  8  in-service register
- highest_in_service  out  8  one-hot highest-priority ISR bit, or 0

Behaviour:
Reset:
- Async reset clears isr, clear_irr, int_req, ack_level, ack_valid, and the state.
- Priority pointer lowest_pri is set to LOWEST_PRI_RESET.

Priority:
- Priority order is lowest_pri+1 (highest) through lowest_pri (lowest), mod 8, with wrap-around.

Candidate selection:
- Candidate set: irr & ~imr.
- Normal mode: the winner is the highest-priority candidate that is strictly higher than the highest isr bit.
- SMM: the winner is the highest-priority candidate that is not set in isr. isr does not block other levels.

FSM states: IDLE, REQ, ACK.
- IDLE -> REQ when a winner exists. int_req is registered and asserts the cycle after the winner appears.
- REQ -> IDLE if the winner disappears before ack1; int_req drops.
- IDLE/REQ + ack1 -> ACK:
  - The winner is latched into ack_level with ack_valid=1.
  - isr[level] is set and clear_irr pulses for one cycle.
  - int_req is cleared.
  - With no winner (spurious): ack_level=7, ack_valid=0, isr unchanged, no clear_irr.
- ACK: the latched level is frozen; irr changes are ignored.
- ACK + ack2 -> IDLE. If auto_eoi and ack_valid, clear isr[ack_level]; if auto_rotate as well, lowest_pri <= ack_level.
- poll in IDLE/REQ: same latch and ISR set as ack1, then returns directly to IDLE. int_req is cleared.
- ack1 while in ACK is ignored. ack2 outside ACK is ignored.

Commands (one cycle, processed in any state):
- eoi_nonspecific: clear the highest-priority isr bit; no-op if isr==0. If rotate, lowest_pri <= that level.
- eoi_specific: clear isr[cmd_level]. If rotate, lowest_pri <= cmd_level.
- set_priority: lowest_pri <= cmd_level.

Simultaneous events:
- When an ISR set (ack1/poll) and a clear target the same bit in one cycle, the set wins.
- Pointer updates: set_priority beats EOI-rotate, which beats AEOI-rotate.

highest_in_service:
- Combinational from isr and lowest_pri.

Optional Feature:
PIC_SPECIAL_FULLY_NESTED_EN:
- When defined, adds input special_fully_nested (1 bit, ICW4 SFNM). When it is set, a candidate at the same level as the highest isr bit also qualifies, so cascaded slaves can re-interrupt.
- When undefined, the port is absent and only strictly higher levels qualify.

Decomposition:
- Package pic_pkg:
  - state enum {IDLE, REQ, ACK}
  - LEVEL_W=3
  - SPURIOUS_LEVEL=3'd7
  - functions rotate_right8, rotate_left8, and the one-hot-to-index encoder
- Sub-module pic_priority_encoder: takes an 8-bit vector and lowest_pri; returns found, level, and one-hot. Instantiated twice, for the candidate set and for isr.

Test Plan:
- irr=8'h0A, imr=0, reset pointer -> int_req high the next cycle; ack1 gives ack_level=1, ack_valid=1, isr=8'h02, clear_irr=8'h02 for one cycle.
- isr=8'h02, irr rises to 8'h01 -> int_req asserts. irr=8'h08 alone -> int_req stays low until eoi_nonspecific clears isr, then asserts.
- ack1 with irr dropped to 0 -> ack_level=7, ack_valid=0, isr unchanged; ack2 returns to IDLE.
- auto_eoi=1, auto_rotate=1, irr=8'h10, full ack1/ack2 -> isr=0 after ack2; lowest_pri=4, so IR5 is now highest priority (irr=8'h21 gives ack_level 5).
- Set SMM, imr=8'h02, isr=8'h02, irr=8'h80 -> int_req asserts; ack1 gives ack_level 7, ack_valid=1.
- ack1 and eoi_specific(cmd_level=3) in the same cycle, winner IR3 -> isr[3]=1. Then assert reset mid-ACK -> all outputs return to reset values immediately.
